// File: rtl/mdu.sv
// +--------------------------------------------------------------------------+
// | Module   : mdu                                                           |
// | Purpose  : Multi-cycle multiply/divide unit owning the HI/LO registers.  |
// |            mult/multu take 5 cycles and div/divu take 10 cycles. HI/LO   |
// |            are written only on the completing edge, so partial results   |
// |            are never visible. mthi/mtlo write with zero latency when     |
// |            the unit is idle.                                             |
// | Ports    : clk    - clock, rising edge                                   |
// |            rst_n  - asynchronous active-low reset                        |
// |            A, B   - EX-stage operands (same as ALU A/B)                  |
// |            Op     - 0001 mult, 0010 multu, 0011 div, 0100 divu,          |
// |                     0101 mthi, 0110 mtlo, others no-op                   |
// |            Start  - one-cycle launch request for mult/multu/div/divu     |
// |            Busy   - operation in progress                                |
// |            HI, LO - architectural HI/LO registers                        |
// | Config   : MDU_DIV0_HOLD_EN - when defined, div/divu by zero still runs  |
// |            the full 10 cycles but leaves HI/LO unchanged. When           |
// |            undefined, divide by zero yields the natural restoring-       |
// |            divider result (LO all ones or 1, HI = dividend).             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] C_OP_MULT  = 4'b0001;
  localparam logic [3:0] C_OP_MULTU = 4'b0010;
  localparam logic [3:0] C_OP_DIV   = 4'b0011;
  localparam logic [3:0] C_OP_DIVU  = 4'b0100;
  localparam logic [3:0] C_OP_MTHI  = 4'b0101;
  localparam logic [3:0] C_OP_MTLO  = 4'b0110;

  localparam logic [3:0] C_LAT_MUL  = 4'd5;
  localparam logic [3:0] C_LAT_DIV  = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mag_a;   // multiplicand magnitude
  logic [31:0] r_mag_b;   // divisor magnitude
  logic [31:0] r_work;    // mult: remaining multiplier bits; div: dividend in / quotient out
  logic [63:0] r_acc;     // product magnitude accumulator
  logic [32:0] r_rem;     // partial remainder, one spare bit for the pre-compare shift
  logic [5:0]  r_shamt;   // bit position of the current multiplier byte
  logic        r_neg_q;   // negate product / quotient at commit
  logic        r_neg_r;   // negate remainder at commit (sign follows dividend)
`ifdef MDU_DIV0_HOLD_EN
  logic        r_div0;
`endif

  logic        w_op_mul;
  logic        w_op_div;
  logic        w_signed;
  logic        w_launch;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [39:0] w_pp;
  logic [63:0] w_pp_sh;
  logic [32:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [63:0] w_prod;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // ---------------------------------------------------------------------
  // Launch decode. Signed ops work on magnitudes; the sign is reapplied at
  // commit. -2^31 maps to 2^31, which is representable as unsigned 32-bit.
  // ---------------------------------------------------------------------
  assign w_op_mul = (Op == C_OP_MULT) || (Op == C_OP_MULTU);
  assign w_op_div = (Op == C_OP_DIV)  || (Op == C_OP_DIVU);
  assign w_signed = (Op == C_OP_MULT) || (Op == C_OP_DIV);
  assign w_launch = (r_state == S_IDLE) && Start && (w_op_mul || w_op_div);

  assign w_abs_a = (w_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_abs_b = (w_signed && B[31]) ? (~B + 32'd1) : B;

  // ---------------------------------------------------------------------
  // Multiply datapath: one 32x8 partial product per cycle, four cycles.
  // ---------------------------------------------------------------------
  assign w_pp    = {8'd0, r_mag_a} * {32'd0, r_work[7:0]};
  assign w_pp_sh = {24'd0, w_pp} << r_shamt;

  // ---------------------------------------------------------------------
  // Divide datapath: four restoring-division bits per cycle, eight cycles.
  // With a zero divisor every compare succeeds, so the quotient becomes
  // all ones and the remainder collects the dividend.
  // ---------------------------------------------------------------------
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_work;
    for (int i = 0; i < 4; i++) begin
      w_rem_nx = {w_rem_nx[31:0], w_quo_nx[31]};
      w_quo_nx = {w_quo_nx[30:0], 1'b0};
      if (w_rem_nx >= {1'b0, r_mag_b}) begin
        w_rem_nx    = w_rem_nx - {1'b0, r_mag_b};
        w_quo_nx[0] = 1'b1;
      end
    end
  end

  // Sign restoration applied on the commit edge only.
  assign w_prod    = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo_fix = r_neg_q ? (~r_work + 32'd1) : r_work;
  assign w_rem_fix = r_neg_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

  // ---------------------------------------------------------------------
  // Control / state. r_count holds the remaining busy cycles; the edge on
  // which it reads 1 is the commit edge. Multiply steps while count is 5..2,
  // divide steps while count is 10..3; count 2 of a divide is a spare cycle
  // that keeps the architectural latency at 10.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_mag_a <= 32'd0;
      r_mag_b <= 32'd0;
      r_work  <= 32'd0;
      r_acc   <= 64'd0;
      r_rem   <= 33'd0;
      r_shamt <= 6'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`ifdef MDU_DIV0_HOLD_EN
      r_div0  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= w_op_mul ? S_MUL : S_DIV;
            r_count <= w_op_mul ? C_LAT_MUL : C_LAT_DIV;
            r_mag_a <= w_abs_a;
            r_mag_b <= w_abs_b;
            r_work  <= w_op_mul ? w_abs_b : w_abs_a;
            r_acc   <= 64'd0;
            r_rem   <= 33'd0;
            r_shamt <= 6'd0;
            r_neg_q <= w_signed && (A[31] ^ B[31]);
            r_neg_r <= w_signed && A[31];
`ifdef MDU_DIV0_HOLD_EN
            r_div0  <= (B == 32'd0);
`endif
          end else if (Op == C_OP_MTHI) begin
            r_hi <= A;
          end else if (Op == C_OP_MTLO) begin
            r_lo <= A;
          end
        end

        S_MUL: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= S_IDLE;
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
          end else begin
            r_acc   <= r_acc + w_pp_sh;
            r_work  <= {8'd0, r_work[31:8]};
            r_shamt <= r_shamt + 6'd8;
          end
        end

        S_DIV: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= S_IDLE;
`ifdef MDU_DIV0_HOLD_EN
            if (!r_div0) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
`else
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
`endif
          end else if (r_count >= 4'd3) begin
            r_rem  <= w_rem_nx;
            r_work <= w_quo_nx;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_count <= 4'd0;
        end
      endcase
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_mdu                                                        |
// | Purpose  : Directed self-checking bench for mdu. Inputs are driven and   |
// |            outputs sampled on the falling clock edge.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mdu;

  localparam logic [3:0] C_MULT  = 4'b0001;
  localparam logic [3:0] C_MULTU = 4'b0010;
  localparam logic [3:0] C_DIV   = 4'b0011;
  localparam logic [3:0] C_DIVU  = 4'b0100;
  localparam logic [3:0] C_MTHI  = 4'b0101;
  localparam logic [3:0] C_MTLO  = 4'b0110;
  localparam logic [3:0] C_NOP   = 4'b0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;
  int cyc;

  mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count falling edges with Busy high, bounded.
  task automatic wait_idle(inout int n);
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Launch one operation, scramble operands afterwards, wait for completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    Op = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP; A = 32'hDEADBEEF; B = 32'h13579BDF;
    n = 0;
    wait_idle(n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; A = 32'd0; B = 32'd0; Op = C_NOP; Start = 1'b0;

    // Reset state, asynchronous (before any rising edge)
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_hi", {32'd0, HI}, 64'd0);
    chk("rst_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // mult -2 * 3
    run_op(C_MULT, 32'hFFFFFFFE, 32'd3, cyc);
    chk("mult_cycles", cyc, 64'd5);
    chk("mult_hi", {32'd0, HI}, 64'hFFFFFFFF);
    chk("mult_lo", {32'd0, LO}, 64'hFFFFFFFA);

    // divu 100 / 7
    run_op(C_DIVU, 32'd100, 32'd7, cyc);
    chk("divu_cycles", cyc, 64'd10);
    chk("divu_lo", {32'd0, LO}, 64'd14);
    chk("divu_hi", {32'd0, HI}, 64'd2);

    // div -7 / 2
    run_op(C_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    chk("div_neg_lo", {32'd0, LO}, 64'hFFFFFFFD);
    chk("div_neg_hi", {32'd0, HI}, 64'hFFFFFFFF);

    // div overflow case
    run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    chk("div_ovf_lo", {32'd0, LO}, 64'h80000000);
    chk("div_ovf_hi", {32'd0, HI}, 64'd0);

    // mthi / Start ignored while a mult (7 * -3) runs
    @(negedge clk);
    Op = C_MULT; A = 32'd7; B = 32'hFFFFFFFD; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = C_MTHI; A = 32'h12345678; B = 32'd0;
    chk("busy_launch", {63'd0, Busy}, 64'd1);
    @(negedge clk);
    chk("hold_hi_busy", {32'd0, HI}, 64'd0);
    Start = 1'b1; Op = C_DIV; A = 32'd1; B = 32'd1;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP;
    chk("hold_hi_busy2", {32'd0, HI}, 64'd0);
    chk("hold_lo_busy", {32'd0, LO}, 64'h80000000);
    cyc = 2;
    wait_idle(cyc);
    chk("mult_busy_cycles", cyc, 64'd5);
    chk("mult_neg_hi", {32'd0, HI}, 64'hFFFFFFFF);
    chk("mult_neg_lo", {32'd0, LO}, 64'hFFFFFFEB);
    Op = C_MTHI; A = 32'h12345678;
    @(negedge clk);
    Op = C_NOP;
    chk("mthi_hi", {32'd0, HI}, 64'h12345678);
    chk("mthi_busy", {63'd0, Busy}, 64'd0);
    Start = 1'b1; Op = C_MTLO; A = 32'h0BADF00D;
    @(negedge clk);
    chk("mtlo_busy", {63'd0, Busy}, 64'd0);
    chk("mtlo_lo", {32'd0, LO}, 64'h0BADF00D);
    Op = 4'b1111;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP;
    chk("nop_busy", {63'd0, Busy}, 64'd0);
    chk("nop_hi", {32'd0, HI}, 64'h12345678);

    // Extreme multiplies
    run_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    chk("multu_max_hi", {32'd0, HI}, 64'hFFFFFFFE);
    chk("multu_max_lo", {32'd0, LO}, 64'h00000001);
    run_op(C_MULT, 32'h80000000, 32'h80000000, cyc);
    chk("mult_min_hi", {32'd0, HI}, 64'h40000000);
    chk("mult_min_lo", {32'd0, LO}, 64'd0);

    // Divide by zero with HI/LO preloaded
    @(negedge clk);
    Op = C_MTHI; A = 32'hAAAAAAAA;
    @(negedge clk);
    Op = C_MTLO;
    run_op(C_DIV, 32'd5, 32'd0, cyc);
    chk("div0_cycles", cyc, 64'd10);
`ifdef MDU_DIV0_HOLD_EN
    chk("div0_lo", {32'd0, LO}, 64'hAAAAAAAA);
    chk("div0_hi", {32'd0, HI}, 64'hAAAAAAAA);
`else
    chk("div0_lo", {32'd0, LO}, 64'hFFFFFFFF);
    chk("div0_hi", {32'd0, HI}, 64'd5);
    run_op(C_DIV, 32'hFFFFFFFB, 32'd0, cyc);
    chk("div0_neg_lo", {32'd0, LO}, 64'd1);
    chk("div0_neg_hi", {32'd0, HI}, 64'hFFFFFFFB);
    run_op(C_DIVU, 32'd7, 32'd0, cyc);
    chk("divu0_lo", {32'd0, LO}, 64'hFFFFFFFF);
    chk("divu0_hi", {32'd0, HI}, 64'd7);
`endif

    // Back-to-back: multu then divu launched as soon as Busy falls
    @(negedge clk);
    Op = C_MULTU; A = 32'hFFFFFFFF; B = 32'd2; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP;
    cyc = 0;
    wait_idle(cyc);
    chk("b2b_first_cycles", cyc, 64'd5);
    chk("b2b_first_hi", {32'd0, HI}, 64'd1);
    chk("b2b_first_lo", {32'd0, LO}, 64'hFFFFFFFE);
    Op = C_DIVU; A = 32'd50; B = 32'd6; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP;
    chk("b2b_second_busy", {63'd0, Busy}, 64'd1);
    cyc = 0;
    wait_idle(cyc);
    chk("b2b_second_cycles", cyc, 64'd10);
    chk("b2b_second_lo", {32'd0, LO}, 64'd8);
    chk("b2b_second_hi", {32'd0, HI}, 64'd2);

    // Reset during the third busy cycle of a div
    @(negedge clk);
    Op = C_DIV; A = 32'd1000; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = C_NOP;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_hi", {32'd0, HI}, 64'd0);
    chk("midrst_lo", {32'd0, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("postrst_hilo_busy", {HI, LO[30:0], Busy}, 64'd0);
    end

    // First launch after reset
    run_op(C_MULT, 32'd6, 32'd7, cyc);
    chk("postrst_mult_cycles", cyc, 64'd5);
    chk("postrst_mult_lo", {32'd0, LO}, 64'd42);
    chk("postrst_mult_hi", {32'd0, HI}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
